// File: rtl/fifo_rr_read_scheduler_if.sv
// Signal bundle between the router input FIFOs, the read scheduler and the flit consumer.
// The scheduler takes the master view; the FIFO/consumer side takes the slave view.
interface fifo_rr_read_scheduler_if #(
  parameter int NUM_PORTS = 7,
  parameter int FLIT_W    = 85
);
  logic [NUM_PORTS-1:0]        fifo_empty;
  logic [NUM_PORTS*FLIT_W-1:0] fifo_data;
  logic [NUM_PORTS-1:0]        fifo_rd_en;
  logic [FLIT_W-1:0]           out_flit;
  logic                        out_valid;
  logic                        out_ready;
  logic [2:0]                  out_port;
  logic [7:0]                  drop_count;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_flit, out_valid, out_port, drop_count
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_flit, out_valid, out_port, drop_count
  );
endinterface

// File: rtl/fifo_rr_read_scheduler.sv
// Round-robin read scheduler sharing one flit consumer among NUM_PORTS input FIFOs;
// one read outstanding at a time, invalid flits are dropped and counted.
//
// state   | meaning
// IDLE    | waiting for any non-empty FIFO, arbitrates when one appears
// READ    | rd_en pulse to the granted FIFO
// CAPTURE | FIFO registered output valid; latch flit, keep or drop it
// SEND    | flit presented on out_*, waiting for out_ready
module fifo_rr_read_scheduler #(
  parameter int NUM_PORTS    = 7,
  parameter int lg_numprocs  = 3,
  parameter int PayloadWidth = 32
) (
  input logic                       clk,
  input logic                       rst,
  fifo_rr_read_scheduler_if.master  bus
);
  localparam int FLIT_W    = 82 + lg_numprocs;
  localparam int VALID_BIT = 81;
  localparam logic [2:0]           LAST_RST = 3'(NUM_PORTS - 1);
  localparam logic [NUM_PORTS-1:0] ONE      = 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
    $error("NUM_PORTS must be in 2..8");
  end
  if (PayloadWidth > VALID_BIT) begin : g_bad_payload
    $error("PayloadWidth overlaps the flit valid bit");
  end

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, SEND} state_t;

  state_t            state, state_nxt;
  logic [2:0]        grant, grant_nxt;
  logic [2:0]        last_grant, last_grant_nxt;
  logic [FLIT_W-1:0] flit_q, flit_nxt;
  logic              valid_q, valid_nxt;
  logic [2:0]        port_q, port_nxt;
  logic [7:0]        drops_q, drops_nxt;

  logic              pending;
  logic [2:0]        winner;
  logic [3:0]        idx;
  logic [FLIT_W-1:0] flit_sel;

  assign flit_sel = bus.fifo_data[int'(grant)*FLIT_W +: FLIT_W];

  // Scan starts one past the previous grant so every non-empty port is reached
  // within NUM_PORTS arbitrations.
  always_comb begin
    pending = 1'b0;
    winner  = last_grant;
    idx     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = {1'b0, last_grant} + 4'(i);
      if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
      if (!pending && !bus.fifo_empty[idx[2:0]]) begin
        pending = 1'b1;
        winner  = idx[2:0];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    flit_nxt       = flit_q;
    valid_nxt      = valid_q;
    port_nxt       = port_q;
    drops_nxt      = drops_q;
    case (state)
      IDLE: begin
        if (pending) begin
          grant_nxt      = winner;
          last_grant_nxt = winner;
          state_nxt      = READ;
        end
      end
      READ: state_nxt = CAPTURE;
      CAPTURE: begin
        flit_nxt = flit_sel;
        port_nxt = grant;
        if (flit_sel[VALID_BIT]) begin
          valid_nxt = 1'b1;
          state_nxt = SEND;
        end else begin
          if (drops_q != 8'hFF) drops_nxt = drops_q + 8'd1;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          valid_nxt = 1'b0;
          if (pending) begin
            grant_nxt      = winner;
            last_grant_nxt = winner;
            state_nxt      = READ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_RST;
      flit_q     <= '0;
      valid_q    <= 1'b0;
      port_q     <= '0;
      drops_q    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      flit_q     <= flit_nxt;
      valid_q    <= valid_nxt;
      port_q     <= port_nxt;
      drops_q    <= drops_nxt;
    end
  end

  // Decoded from the registered state so a reset kills the pulse immediately.
  assign bus.fifo_rd_en = (state == READ) ? (ONE << grant) : '0;
  assign bus.out_flit   = flit_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_port   = port_q;
  assign bus.drop_count = drops_q;

endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// Bench for fifo_rr_read_scheduler: FIFOs emulated with queues, expected read order and
// output stream produced by a transaction-level round-robin model.
module tb_fifo_rr_read_scheduler;
  localparam int NP  = 7;
  localparam int LGP = 3;
  localparam int FW  = 82 + LGP;

  typedef logic [FW-1:0] flit_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rr_read_scheduler_if #(.NUM_PORTS(NP), .FLIT_W(FW)) bus ();

  fifo_rr_read_scheduler #(.NUM_PORTS(NP), .lg_numprocs(LGP), .PayloadWidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flit_t fq [NP][$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  int    obs_rd_port[$];
  int    obs_rd_cyc[$];
  int    obs_out_port[$];
  flit_t obs_out_flit[$];
  int    obs_out_cyc[$];

  int    exp_rd[$];
  int    exp_port[$];
  flit_t exp_flit[$];
  int    m_last;
  int    m_drops;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic flit_t mk_flit(input bit v);
    logic [127:0] r;
    flit_t f;
    r = {$urandom, $urandom, $urandom, $urandom};
    f = r[FW-1:0];
    f[81] = v;
    return f;
  endfunction

  task automatic refresh_empty();
    for (int p = 0; p < NP; p++) bus.fifo_empty[p] = (fq[p].size() == 0);
  endtask

  task automatic push(input int p, input flit_t f);
    fq[p].push_back(f);
    refresh_empty();
  endtask

  // One clock: observe at negedge, then emulate the FIFOs' registered read port.
  task automatic tick();
    logic [NP-1:0] rd;
    @(negedge clk);
    rd = bus.fifo_rd_en;
    if (rd != '0) begin
      check("rd_onehot", $onehot(rd), 1);
      for (int p = 0; p < NP; p++)
        if (rd[p]) begin
          obs_rd_port.push_back(p);
          obs_rd_cyc.push_back(cyc);
        end
    end
    if (bus.out_valid && bus.out_ready) begin
      obs_out_port.push_back(int'(bus.out_port));
      obs_out_flit.push_back(bus.out_flit);
      obs_out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++)
      if (rd[p]) begin
        if (fq[p].size() != 0) bus.fifo_data[p*FW +: FW] = fq[p].pop_front();
        else                   bus.fifo_data[p*FW +: FW] = '0;
      end
    refresh_empty();
  endtask

  // Round-robin over current FIFO contents; empties change only through the scheduler's reads.
  task automatic model_schedule();
    flit_t mq [NP][$];
    int    w;
    int    id;
    flit_t f;
    bit    done;
    mq   = fq;
    done = 1'b0;
    for (int n = 0; n < 4096 && !done; n++) begin
      w = -1;
      for (int i = 1; i <= NP; i++) begin
        id = (m_last + i) % NP;
        if (w < 0 && mq[id].size() != 0) w = id;
      end
      if (w < 0) begin
        done = 1'b1;
      end else begin
        m_last = w;
        f = mq[w].pop_front();
        exp_rd.push_back(w);
        if (f[81]) begin
          exp_port.push_back(w);
          exp_flit.push_back(f);
        end else begin
          m_drops++;
        end
      end
    end
  endtask

  task automatic clear_all();
    obs_rd_port.delete();  obs_rd_cyc.delete();
    obs_out_port.delete(); obs_out_flit.delete(); obs_out_cyc.delete();
    exp_rd.delete(); exp_port.delete(); exp_flit.delete();
  endtask

  task automatic drain(input int prob, input int max_cyc);
    int n;
    n = 0;
    while (!(obs_rd_port.size() >= exp_rd.size() && obs_out_port.size() >= exp_port.size()
             && !bus.out_valid && bus.fifo_empty == '1) && n < max_cyc) begin
      bus.out_ready = ($urandom_range(99) < prob);
      tick();
      n++;
    end
    check("drain_in_budget", n < max_cyc, 1);
    bus.out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic compare_all(input string tag);
    int dsat;
    check({tag, "_n_reads"}, obs_rd_port.size(), exp_rd.size());
    for (int i = 0; i < obs_rd_port.size() && i < exp_rd.size(); i++)
      check({tag, "_rd_port"}, obs_rd_port[i], exp_rd[i]);
    check({tag, "_n_out"}, obs_out_port.size(), exp_port.size());
    for (int i = 0; i < obs_out_port.size() && i < exp_port.size(); i++) begin
      check({tag, "_out_port"}, obs_out_port[i], exp_port[i]);
      check({tag, "_out_flit"}, obs_out_flit[i], exp_flit[i]);
    end
    dsat = (m_drops > 255) ? 255 : m_drops;
    check({tag, "_drop_count"}, bus.drop_count, dsat);
    clear_all();
  endtask

  task automatic quiet_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_last  = NP - 1;
    m_drops = 0;
    clear_all();
  endtask

  initial begin
    flit_t f, hold;
    int    c0, vcyc, hcyc, nrd;

    rst = 1'b1;
    bus.out_ready  = 1'b0;
    bus.fifo_data  = '0;
    bus.fifo_empty = '1;
    repeat (2) @(negedge clk);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_flit", bus.out_flit, 0);
    check("rst_out_port", bus.out_port, 0);
    check("rst_drop_count", bus.drop_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_last  = NP - 1;
    m_drops = 0;
    clear_all();

    // single port 3, latency and capture
    f = mk_flit(1'b1);
    f[31:0] = 32'h0000_00A5;
    push(3, f);
    model_schedule();
    c0   = cyc;
    vcyc = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid && vcyc < 0) vcyc = cyc;
    end
    check("single_n_rd", obs_rd_port.size(), 1);
    if (obs_rd_port.size() > 0) begin
      check("single_rd_port", obs_rd_port[0], 3);
      check("single_rd_cycle", obs_rd_cyc[0] - c0, 1);
    end
    check("single_latency", vcyc - c0, 3);
    check("single_out_port", bus.out_port, 3);
    check("single_payload", bus.out_flit[31:0], 32'hA5);
    drain(100, 50);
    compare_all("single");

    // round robin from reset, all ports busy
    quiet_reset();
    for (int p = 0; p < NP; p++) push(p, mk_flit(1'b1));
    push(0, mk_flit(1'b1));
    model_schedule();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && obs_out_port.size() < NP + 1; k++) tick();
    check("rr_n_out", obs_out_port.size(), NP + 1);
    for (int i = 0; i < obs_out_port.size() && i < NP + 1; i++)
      check("rr_port_seq", obs_out_port[i], i % NP);
    for (int i = 1; i < obs_out_cyc.size(); i++)
      check("rr_spacing", obs_out_cyc[i] - obs_out_cyc[i-1], 3);
    drain(100, 50);
    compare_all("rr");

    // backpressure with port 1 pending behind port 4
    bus.out_ready = 1'b0;
    push(4, mk_flit(1'b1));
    model_schedule();
    for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
    check("bp_send_up", bus.out_valid, 1);
    push(1, mk_flit(1'b1));
    model_schedule();
    hold = bus.out_flit;
    nrd  = obs_rd_port.size();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid_held", bus.out_valid, 1);
      check("bp_flit_stable", bus.out_flit, hold);
    end
    check("bp_no_rd", obs_rd_port.size(), nrd);
    bus.out_ready = 1'b1;
    hcyc = cyc;
    tick();
    bus.out_ready = 1'b0;
    tick();
    check("bp_next_rd_n", obs_rd_port.size(), nrd + 1);
    if (obs_rd_port.size() == nrd + 1) begin
      check("bp_next_rd_port", obs_rd_port[nrd], 1);
      check("bp_next_rd_cyc", obs_rd_cyc[nrd] - hcyc, 1);
    end
    drain(100, 50);
    compare_all("bp");

    // single drop on port 2
    check("drop_before", bus.drop_count, 0);
    push(2, mk_flit(1'b0));
    model_schedule();
    vcyc = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.out_valid) vcyc = 1;
    end
    check("drop_no_valid", vcyc, 0);
    check("drop_count_one", bus.drop_count, 1);
    drain(100, 50);
    compare_all("drop");

    // port 5 emptied by someone else between arbitration and READ
    push(5, mk_flit(1'b1));
    tick();
    fq[5].delete();
    refresh_empty();
    m_last = 5;
    exp_rd.push_back(5);
    m_drops++;
    vcyc = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.out_valid) vcyc = 1;
    end
    check("late_no_valid", vcyc, 0);
    check("late_drop_count", bus.drop_count, 2);
    compare_all("late");

    // drop counter saturation
    for (int k = 0; k < 300; k++) push(2, mk_flit(1'b0));
    model_schedule();
    drain(100, 2000);
    check("drop_saturated", bus.drop_count, 8'd255);
    compare_all("sat");

    // asynchronous reset in the middle of SEND
    bus.out_ready = 1'b0;
    push(6, mk_flit(1'b1));
    for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
    check("mid_send_up", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", bus.fifo_rd_en, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_flit", bus.out_flit, 0);
    check("mid_rst_port", bus.out_port, 0);
    check("mid_rst_drops", bus.drop_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_last  = NP - 1;
    m_drops = 0;
    clear_all();
    push(5, mk_flit(1'b1));
    push(0, mk_flit(1'b1));
    model_schedule();
    drain(100, 50);
    if (obs_rd_port.size() > 0) check("post_rst_first", obs_rd_port[0], 0);
    else                        check("post_rst_first_seen", obs_rd_port.size(), 2);
    compare_all("post_rst");

    // randomized contents and backpressure
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NP; p++) begin
        int n;
        n = $urandom_range(6);
        for (int k = 0; k < n; k++) push(p, mk_flit($urandom_range(4) != 0));
      end
      model_schedule();
      drain($urandom_range(100, 20), 3000);
      compare_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
